// File: rtl/uart_cmd_decoder_if.sv
// uart_cmd_decoder_if: byte-stream input and decoded command outputs of uart_cmd_decoder.
interface uart_cmd_decoder_if #(parameter int NUM_CMD = 4);
    localparam int ID_W = NUM_CMD > 1 ? $clog2(NUM_CMD) : 1;
    logic [7:0]         rx_data;
    logic               rx_valid;
    logic [NUM_CMD-1:0] cmd_pulse;
    logic [NUM_CMD-1:0] cmd_hold;
    logic [ID_W-1:0]    cmd_id;
    logic               busy;
    logic               frame_err;
    modport master(output rx_data, rx_valid, input cmd_pulse, cmd_hold, cmd_id, busy, frame_err);
    modport slave(input rx_data, rx_valid, output cmd_pulse, cmd_hold, cmd_id, busy, frame_err);
endinterface

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: sliding-window UART command matcher with pulse/hold outputs and inter-byte timeout.
// Define UART_CMD_RETRIGGER_EN to let a new command restart an active hold.
module uart_cmd_decoder #(
    parameter int CMD_LEN = 2,
    parameter int NUM_CMD = 4,
    parameter logic [NUM_CMD*CMD_LEN*8-1:0] CMD_TABLE = "Q4Q3Q2Q1",
    parameter int HOLD_CYC = 10,
    parameter int TIMEOUT_CYC = 1000000
) (
    input logic clk,
    input logic rst,
    uart_cmd_decoder_if.slave bus
);
    localparam int W = CMD_LEN * 8;
    localparam int ID_W = NUM_CMD > 1 ? $clog2(NUM_CMD) : 1;
    localparam int FW = $clog2(CMD_LEN + 1);
    localparam int HW = HOLD_CYC > 1 ? $clog2(HOLD_CYC) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC);
`ifdef UART_CMD_RETRIGGER_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

    state_t state, state_n;
    logic [W-1:0] window, window_n, win_shift;
    logic [W+7:0] win_cat;
    logic [FW-1:0] fill, fill_n, fill_nx;
    logic [HW-1:0] hcnt, hcnt_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic [NUM_CMD-1:0] pulse_q, pulse_n;
    logic [ID_W-1:0] id_q, id_n, hit_id;
    logic ferr_q, ferr_n;
    logic acc, hit, counting, tterm, hterm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            window <= '0;
            fill <= '0;
            hcnt <= '0;
            tcnt <= '0;
            pulse_q <= '0;
            id_q <= '0;
            ferr_q <= 1'b0;
        end else begin
            state <= state_n;
            window <= window_n;
            fill <= fill_n;
            hcnt <= hcnt_n;
            tcnt <= tcnt_n;
            pulse_q <= pulse_n;
            id_q <= id_n;
            ferr_q <= ferr_n;
        end
    end

    always_comb begin
        acc = bus.rx_valid && (RETRIG || state != HOLD);
        win_cat = {window, bus.rx_data};
        win_shift = win_cat[W-1:0];
        fill_nx = fill == FW'(CMD_LEN) ? fill : fill + 1'b1;
        counting = state == COLLECT || (RETRIG && state == HOLD);
        tterm = tcnt == TW'(TIMEOUT_CYC - 1);
        hterm = hcnt == HW'(HOLD_CYC - 1);
        hit = 1'b0;
        hit_id = '0;
        // Descending scan so the lowest matching index is the one kept
        for (int i = NUM_CMD - 1; i >= 0; i--) begin
            if (win_shift == CMD_TABLE[i*W +: W]) begin
                hit = 1'b1;
                hit_id = ID_W'(i);
            end
        end
        hit = hit && acc && fill_nx == FW'(CMD_LEN);
        state_n = state;
        window_n = window;
        fill_n = fill;
        hcnt_n = hcnt;
        tcnt_n = tcnt;
        pulse_n = '0;
        id_n = id_q;
        ferr_n = 1'b0;
        if (acc) begin
            window_n = win_shift;
            fill_n = fill_nx;
            tcnt_n = '0;
            state_n = state == IDLE ? COLLECT : state;
        end else if (counting) begin
            window_n = tterm ? '0 : window;
            fill_n = tterm ? '0 : fill;
            tcnt_n = tterm ? '0 : tcnt + 1'b1;
            ferr_n = tterm;
            state_n = tterm && state == COLLECT ? IDLE : state;
        end
        if (state == HOLD) begin
            hcnt_n = hterm ? '0 : hcnt + 1'b1;
            if (hterm) begin
                state_n = IDLE;
                window_n = '0;
                fill_n = '0;
                tcnt_n = '0;
            end
        end
        // A match overrides everything else and (re)starts the hold
        if (hit) begin
            state_n = HOLD;
            hcnt_n = '0;
            window_n = '0;
            fill_n = '0;
            tcnt_n = '0;
            pulse_n = NUM_CMD'(1) << hit_id;
            id_n = hit_id;
        end
    end

    assign bus.cmd_pulse = pulse_q;
    assign bus.busy = state == HOLD;
    assign bus.cmd_hold = state == HOLD ? NUM_CMD'(1) << id_q : '0;
    assign bus.cmd_id = id_q;
    assign bus.frame_err = ferr_q;
endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb_uart_cmd_decoder: scoreboard bench; stimulus pushes expected events, a negedge monitor pops and compares.
module tb_uart_cmd_decoder;
    localparam int T = 50;
    localparam int H = 10;
    localparam int K_PULSE = 0, K_FERR = 1, K_HEND = 2;

    typedef struct {
        int kind;
        int cyc;
        logic [3:0] pulse;
        logic [1:0] id;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int pe = 0;
    int tests = 0;
    int fails = 0;
    logic prev_busy = 1'b0;
    ev_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) pe <= pe + 1;

    uart_cmd_decoder_if #(.NUM_CMD(4)) bus();
    uart_cmd_decoder #(.HOLD_CYC(H), .TIMEOUT_CYC(T)) dut(.clk(clk), .rst(rst), .bus(bus));

    task automatic push(input int kind, input int cyc, input logic [3:0] pulse, input logic [1:0] id);
        ev_t e;
        e.kind = kind;
        e.cyc = cyc;
        e.pulse = pulse;
        e.id = id;
        sb.push_back(e);
    endtask

    task automatic check_ev(input int kind);
        ev_t e;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $display("FAIL event: unexpected kind=%0d at cyc %0d pulse=%b id=%0d", kind, pe, bus.cmd_pulse, bus.cmd_id);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || e.cyc != pe || (kind == K_PULSE && (bus.cmd_pulse != e.pulse ||
                bus.cmd_hold != e.pulse || bus.cmd_id != e.id || !bus.busy))) begin
                fails++;
                $display("FAIL event: got kind=%0d cyc=%0d pulse=%b hold=%b id=%0d busy=%b, expected kind=%0d cyc=%0d pulse=%b id=%0d",
                         kind, pe, bus.cmd_pulse, bus.cmd_hold, bus.cmd_id, bus.busy, e.kind, e.cyc, e.pulse, e.id);
            end
        end
    endtask

    always @(negedge clk) begin
        if (bus.cmd_pulse != '0) check_ev(K_PULSE);
        if (bus.frame_err) check_ev(K_FERR);
        if (prev_busy && !bus.busy) check_ev(K_HEND);
        prev_busy <= bus.busy;
    end

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic outs_zero(input string name);
        chk({name, "_pulse"}, int'(bus.cmd_pulse), 0);
        chk({name, "_hold"}, int'(bus.cmd_hold), 0);
        chk({name, "_id"}, int'(bus.cmd_id), 0);
        chk({name, "_busy"}, int'(bus.busy), 0);
        chk({name, "_ferr"}, int'(bus.frame_err), 0);
    endtask

    task automatic strobe(input logic [7:0] b);
        bus.rx_data = b;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1 bus.rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_match(input logic [3:0] p, input logic [1:0] id);
        push(K_PULSE, pe, p, id);
        push(K_HEND, pe + H, 4'b0, 2'd0);
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data = 8'h00;
        idle(3);
        outs_zero("reset");
        rst = 1'b0;
        idle(2);
        // basic "Q1"
        strobe("Q"); strobe("1");
        expect_match(4'b0001, 2'd0);
        idle(H + 3);
        chk("id_after_q1", int'(bus.cmd_id), 0);
        // sliding match "xQ3"
        strobe("x"); strobe("Q"); strobe("3");
        expect_match(4'b0100, 2'd2);
        idle(H + 3);
        chk("id_after_q3", int'(bus.cmd_id), 2);
        // timeout discards 'Q'; lone '2' then times out again
        strobe("Q");
        push(K_FERR, pe + T, 4'b0, 2'd0);
        idle(T);
        strobe("2");
        push(K_FERR, pe + T, 4'b0, 2'd0);
        idle(T + 2);
        // byte on the terminal timeout cycle wins
        strobe("Q");
        idle(T - 1);
        strobe("4");
        expect_match(4'b1000, 2'd3);
        idle(H + 3);
        chk("id_after_q4", int'(bus.cmd_id), 3);
        // bytes during hold, including the terminal hold cycle, are ignored
        strobe("Q"); strobe("1");
        expect_match(4'b0001, 2'd0);
        strobe("Q"); strobe("2");
        idle(H - 3);
        strobe("Q"); strobe("3");
        push(K_FERR, pe + T, 4'b0, 2'd0);
        idle(T + 3);
        chk("id_after_ignored", int'(bus.cmd_id), 0);
        // reset in hold cycle 5
        strobe("Q"); strobe("2");
        push(K_PULSE, pe, 4'b0010, 2'd1);
        idle(4);
        push(K_HEND, pe, 4'b0, 2'd0);
        rst = 1'b1;
        #1;
        outs_zero("midhold_rst");
        idle(2);
        rst = 1'b0;
        idle(1);
        strobe("Q"); strobe("4");
        expect_match(4'b1000, 2'd3);
        idle(H + 3);
        chk("id_after_rst_q4", int'(bus.cmd_id), 3);
        idle(5);
        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
